cnn_job_scheduler: RTL

- Arbitrates CNN inference jobs from NUM_REQ requesters onto the single conv→maxpool accelerator datapath.
- Sequences each job: clear the datapath, hold enable until done, then return a status response.
- Provides round-robin fairness, a run-cycle timeout, software abort and a per-job cycle count.
- Sits between host-side requesters and the accelerator's en/done pins. The ifmap/weight muxing uses the grant output.

---
 rtl/cnn_job_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cnn_job_scheduler.sv
// Round-robin job scheduler for the shared conv->maxpool accelerator datapath.
// Sequences each job through clear, run and response, with timeout, abort and a run-cycle count.
module cnn_job_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ack,
  output logic [NUM_REQ-1:0] grant,
  output logic               acc_clr,
  output logic               acc_en,
  input  logic               acc_done,
  input  logic               abort,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [1:0]         resp_status,
  output logic [CNT_W-1:0]   resp_run_cycles,
  output logic               busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0]       STATUS_OK      = 2'b00;
  localparam logic [1:0]       STATUS_TIMEOUT = 2'b01;
  localparam logic [1:0]       STATUS_ABORT   = 2'b10;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX       = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [NUM_REQ-1:0] grant_r, grant_nxt_s;
  logic [IDX_W-1:0]   win_r, win_nxt_s;
  logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [1:0]         status_r, status_nxt_s;
  logic [IDX_W-1:0]   pick_s;
  logic               handshake_s;

  // First requester at or after ptr, wrapping; only meaningful when req is non-zero.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic found;
    found   = 1'b0;
    rr_pick = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        rr_pick = IDX_W'(j);
      end
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    idx_to_onehot = NUM_REQ'(1) << idx;
  endfunction

  assign pick_s      = rr_pick(req_valid, rr_ptr_r);
  assign cnt_inc_s   = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
  assign handshake_s = (state_r == ST_RESP) && resp_ready;

  // Next-state, arbitration and job bookkeeping.
  always_comb begin
    state_nxt_s  = state_r;
    grant_nxt_s  = grant_r;
    win_nxt_s    = win_r;
    rr_ptr_nxt_s = rr_ptr_r;
    cnt_nxt_s    = cnt_r;
    status_nxt_s = status_r;
    case (state_r)
      ST_IDLE: begin
        if (|req_valid) begin
          win_nxt_s   = pick_s;
          grant_nxt_s = idx_to_onehot(pick_s);
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        // The exit cycle itself is counted, so decisions use the incremented value.
        cnt_nxt_s = cnt_inc_s;
        if (acc_done) begin
          status_nxt_s = STATUS_OK;
          state_nxt_s  = ST_RESP;
        end else if (abort) begin
          status_nxt_s = STATUS_ABORT;
          state_nxt_s  = ST_RESP;
        end else if (cnt_inc_s >= TIMEOUT_VAL) begin
          status_nxt_s = STATUS_TIMEOUT;
          state_nxt_s  = ST_RESP;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RESP: begin
        if (handshake_s) begin
          grant_nxt_s  = {NUM_REQ{1'b0}};
          rr_ptr_nxt_s = (win_r == LAST_IDX) ? {IDX_W{1'b0}} : win_r + IDX_W'(1);
          state_nxt_s  = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        grant_nxt_s = {NUM_REQ{1'b0}};
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and job registers; reset abandons any job without a response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      grant_r  <= {NUM_REQ{1'b0}};
      win_r    <= {IDX_W{1'b0}};
      rr_ptr_r <= {IDX_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      status_r <= 2'b00;
    end else begin
      state_r  <= state_nxt_s;
      grant_r  <= grant_nxt_s;
      win_r    <= win_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
      cnt_r    <= cnt_nxt_s;
      status_r <= status_nxt_s;
    end
  end

  assign grant           = grant_r;
  assign acc_clr         = (state_r == ST_CLEAR);
  assign acc_en          = (state_r == ST_RUN);
  assign resp_valid      = (state_r == ST_RESP);
  assign busy            = (state_r != ST_IDLE);
  assign resp_status     = status_r;
  assign resp_run_cycles = cnt_r;
  assign req_ack         = handshake_s ? grant_r : {NUM_REQ{1'b0}};

endmodule
